// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the 10-bit screen coordinate type
// used by the timing generator, pixel generator and game-logic position registers.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int PIX_DIV   = 4;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open window test [lo, hi), used for the active-low sync pulses.
  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate enable: a one-clk strobe every PIX_DIV clocks, first strobe in the
// PIX_DIV-th cycle after reset releases.
module pix_clk_en #(
  parameter int PIX_DIV = vga_pkg::PIX_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);
  import vga_pkg::*;

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  end

  // pix_en is registered from div_next so it is high exactly while div_cnt == PIX_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pix_en  <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: scan counters plus registered visible/sync/frame-tick decode,
// all updated once per pixel strobe and aligned to the counts with zero skew.
module vga_timing_gen #(
  parameter int PIX_DIV   = vga_pkg::PIX_DIV,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        pix_en,
  output logic [vga_pkg::COORD_W-1:0] h_cnt,
  output logic [vga_pkg::COORD_W-1:0] v_cnt,
  output logic                        valid,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        frame_tick
);
  import vga_pkg::*;

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t H_SS     = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SE     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_SS     = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SE     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t h_next;
  coord_t v_next;

  pix_clk_en #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_clk_en (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  // Next scan position; the end-of-frame corner wraps both counters together.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_next = h_cnt + coord_t'(1);
      end
    end
  end

  // Decode from the next counts so flags land in the same cycle as the counts they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      valid      <= 1'b1;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      h_cnt      <= h_next;
      v_cnt      <= v_next;
      valid      <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
      hsync      <= !in_span(h_next, H_SS, H_SE);
      vsync      <= !in_span(v_next, V_SS, V_SE);
      frame_tick <= pix_en && (h_next == '0) && (v_next == V_VIS_C);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/divider/line timing, and a shrunken
// geometry instance (25x19 pixels) so frame, vsync, wrap and frame_tick fit a short run.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_s;
  logic       pix_en, valid, hsync, vsync, frame_tick;
  logic [9:0] h_cnt, v_cnt;
  logic       pix_en_s, valid_s, hsync_s, vsync_s, frame_tick_s;
  logic [9:0] h_cnt_s, v_cnt_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  // Small geometry: H 16+2+4+3 = 25, V 12+2+2+3 = 19 -> 100 clk/line, 1900 clk/frame.
  vga_timing_gen #(
    .PIX_DIV   (4),
    .H_VISIBLE (16),
    .H_FRONT   (2),
    .H_SYNC    (4),
    .H_BACK    (3),
    .V_VISIBLE (12),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) dut_s (
    .clk        (clk),
    .rst        (rst_s),
    .pix_en     (pix_en_s),
    .h_cnt      (h_cnt_s),
    .v_cnt      (v_cnt_s),
    .valid      (valid_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .frame_tick (frame_tick_s)
  );

  task automatic check_output(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_stimulus(input logic r, input logic r_s);
    rst   = r;
    rst_s = r_s;
  endtask

  // Line-phase bookkeeping (full-size instance).
  int         wraps, t_wrap0, line_len, hs_low, hs_first, hs_last;
  int         valid_fall_h, valid_fall_prev, wrap_valid, wrap_v;
  int         held_bad, gap_bad, vs_low, ft_cnt, last_pe, n;
  logic [9:0] prev_h, prev_v;
  logic       prev_valid, prev_pe, prev_ft;

  // Frame-phase bookkeeping (small instance).
  int ft_cnt_s, ft_wide, ft_first, ft_h, ft_v, ft_gap;
  int wraps_s, t_wrap_s, frame_len, wrap_valid_s, wrap_hs_s, wrap_vs_s;
  int vs_low_s, vs_first, vs_last, hs_low_s, valid_cnt, valid_bad, held_bad_s, max_v_s;

  initial begin
    apply_stimulus(1'b1, 1'b1);
    repeat (5) tick();
    check_output("rst_h", int'(h_cnt), 0);
    check_output("rst_v", int'(v_cnt), 0);
    check_output("rst_valid", int'(valid), 1);
    check_output("rst_hsync", int'(hsync), 1);
    check_output("rst_vsync", int'(vsync), 1);
    check_output("rst_pix_en", int'(pix_en), 0);
    check_output("rst_frame_tick", int'(frame_tick), 0);
    check_output("rst_valid_small", int'(valid_s), 1);

    // Release the full-size instance; the release cycle counts as cycle 1.
    apply_stimulus(1'b0, 1'b1);
    cyc = 1;
    while (!pix_en && cyc < 20) tick();
    check_output("first_pix_en_cycle", cyc, 4);
    check_output("h_before_first_update", int'(h_cnt), 0);
    tick();
    check_output("h_after_first_pix", int'(h_cnt), 1);
    check_output("pix_en_one_cycle", int'(pix_en), 0);

    wraps = 0; t_wrap0 = 0; line_len = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    valid_fall_h = -1; valid_fall_prev = -1; wrap_valid = -1; wrap_v = -1;
    held_bad = 0; gap_bad = 0; vs_low = 0; ft_cnt = 0; last_pe = 4;
    prev_h = h_cnt; prev_valid = valid; prev_pe = pix_en;
    while (cyc < 7000) begin
      tick();
      if (pix_en) begin
        if (cyc - last_pe != 4) gap_bad++;
        last_pe = cyc;
      end
      if (h_cnt != prev_h && !prev_pe) held_bad++;
      if (frame_tick) ft_cnt++;
      if (!vsync) vs_low++;
      if (prev_h == 10'd799 && h_cnt == 10'd0) begin
        wraps++;
        if (wraps == 1) begin
          t_wrap0    = cyc;
          wrap_valid = int'(valid);
          wrap_v     = int'(v_cnt);
        end else if (wraps == 2) begin
          line_len = cyc - t_wrap0;
        end
      end
      if (wraps == 1 && !hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(h_cnt);
        hs_last = int'(h_cnt);
      end
      if (prev_valid && !valid && valid_fall_h < 0) begin
        valid_fall_h    = int'(h_cnt);
        valid_fall_prev = int'(prev_h);
      end
      prev_h = h_cnt; prev_valid = valid; prev_pe = pix_en;
    end
    check_output("line_wraps", wraps, 2);
    check_output("first_wrap_cycle", t_wrap0, 3201);
    check_output("line_len_clk", line_len, 3200);
    check_output("valid_fall_h", valid_fall_h, 640);
    check_output("valid_fall_prev_h", valid_fall_prev, 639);
    check_output("valid_at_line1_start", wrap_valid, 1);
    check_output("v_after_line_wrap", wrap_v, 1);
    check_output("hsync_low_clk", hs_low, 384);
    check_output("hsync_first_low_h", hs_first, 656);
    check_output("hsync_last_low_h", hs_last, 751);
    check_output("vsync_low_early_lines", vs_low, 0);
    check_output("frame_tick_early", ft_cnt, 0);
    check_output("pix_en_period_errors", gap_bad, 0);
    check_output("h_change_without_pix_en", held_bad, 0);

    // Mid-line reset at h=300.
    n = 0;
    while (h_cnt != 10'd300 && n < 4000) begin
      tick();
      n++;
    end
    check_output("reach_h300", int'(h_cnt), 300);
    apply_stimulus(1'b1, 1'b1);
    tick();
    check_output("midline_rst_h", int'(h_cnt), 0);
    check_output("midline_rst_v", int'(v_cnt), 0);
    check_output("midline_rst_valid", int'(valid), 1);
    check_output("midline_rst_pix_en", int'(pix_en), 0);
    apply_stimulus(1'b0, 1'b1);
    cyc = 1;
    while (!pix_en && cyc < 20) tick();
    check_output("pix_en_after_midline_rst", cyc, 4);

    // Frame phase on the small instance.
    apply_stimulus(1'b1, 1'b0);
    cyc = 1;
    ft_cnt_s = 0; ft_wide = 0; ft_first = -1; ft_h = -1; ft_v = -1; ft_gap = -1;
    wraps_s = 0; t_wrap_s = 0; frame_len = -1; wrap_valid_s = -1; wrap_hs_s = -1; wrap_vs_s = -1;
    vs_low_s = 0; vs_first = -1; vs_last = -1; hs_low_s = 0; valid_cnt = 0; valid_bad = 0;
    held_bad_s = 0; max_v_s = 0;
    prev_h = h_cnt_s; prev_v = v_cnt_s; prev_pe = pix_en_s; prev_ft = frame_tick_s;
    while (cyc < 5000) begin
      tick();
      if ((h_cnt_s != prev_h || v_cnt_s != prev_v) && !prev_pe) held_bad_s++;
      if (int'(v_cnt_s) > max_v_s) max_v_s = int'(v_cnt_s);
      if (frame_tick_s) begin
        ft_cnt_s++;
        if (prev_ft) ft_wide++;
        if (ft_cnt_s == 1) begin
          ft_first = cyc;
          ft_h     = int'(h_cnt_s);
          ft_v     = int'(v_cnt_s);
        end else if (ft_cnt_s == 2) begin
          ft_gap = cyc - ft_first;
        end
      end
      if (prev_h == 10'd24 && prev_v == 10'd18 && h_cnt_s == 10'd0 && v_cnt_s == 10'd0) begin
        wraps_s++;
        if (wraps_s == 1) begin
          t_wrap_s     = cyc;
          wrap_valid_s = int'(valid_s);
          wrap_hs_s    = int'(hsync_s);
          wrap_vs_s    = int'(vsync_s);
        end else if (wraps_s == 2) begin
          frame_len = cyc - t_wrap_s;
        end
      end
      if (wraps_s == 1) begin
        if (!vsync_s) begin
          vs_low_s++;
          if (vs_first < 0) vs_first = int'(v_cnt_s);
          vs_last = int'(v_cnt_s);
        end
        if (!hsync_s) hs_low_s++;
        if (valid_s) valid_cnt++;
        if (valid_s && v_cnt_s >= 10'd12) valid_bad++;
      end
      prev_h = h_cnt_s; prev_v = v_cnt_s; prev_pe = pix_en_s; prev_ft = frame_tick_s;
    end
    check_output("ft_first_cycle", ft_first, 1201);
    check_output("ft_h", ft_h, 0);
    check_output("ft_v", ft_v, 12);
    check_output("ft_spacing", ft_gap, 1900);
    check_output("ft_count", ft_cnt_s, 2);
    check_output("ft_wide_pulses", ft_wide, 0);
    check_output("frame_wraps", wraps_s, 2);
    check_output("first_frame_wrap_cycle", t_wrap_s, 1901);
    check_output("frame_len_clk", frame_len, 1900);
    check_output("wrap_valid", wrap_valid_s, 1);
    check_output("wrap_hsync", wrap_hs_s, 1);
    check_output("wrap_vsync", wrap_vs_s, 1);
    check_output("max_v", max_v_s, 18);
    check_output("vsync_low_clk", vs_low_s, 200);
    check_output("vsync_first_low_v", vs_first, 14);
    check_output("vsync_last_low_v", vs_last, 15);
    check_output("hsync_low_clk_frame", hs_low_s, 304);
    check_output("valid_clk_frame", valid_cnt, 768);
    check_output("valid_in_vblank", valid_bad, 0);
    check_output("small_change_without_pix_en", held_bad_s, 0);

    // Mid-frame reset inside both sync pulses.
    n = 0;
    while (!(v_cnt_s == 10'd14 && h_cnt_s == 10'd19) && n < 3000) begin
      tick();
      n++;
    end
    check_output("reach_v14_h19", int'(v_cnt_s) * 100 + int'(h_cnt_s), 1419);
    check_output("pre_rst_hsync_low", int'(hsync_s), 0);
    check_output("pre_rst_vsync_low", int'(vsync_s), 0);
    apply_stimulus(1'b1, 1'b1);
    tick();
    check_output("midframe_rst_h", int'(h_cnt_s), 0);
    check_output("midframe_rst_v", int'(v_cnt_s), 0);
    check_output("midframe_rst_valid", int'(valid_s), 1);
    check_output("midframe_rst_hsync", int'(hsync_s), 1);
    check_output("midframe_rst_vsync", int'(vsync_s), 1);
    check_output("midframe_rst_frame_tick", int'(frame_tick_s), 0);
    apply_stimulus(1'b1, 1'b0);
    cyc = 1;
    while (!pix_en_s && cyc < 20) tick();
    check_output("pix_en_after_midframe_rst", cyc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
